phase_sequencer: RTL and testbench

PHASE_SEQUENCER -- requirements
Module: phase_sequencer

---
 rtl/phase_sequencer.sv | 167 ++++++++++++++++
 tb/tb_phase_sequencer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/phase_sequencer.sv
// Phase sequencer for a multi-phase puzzle game.
// Walks IDLE -> RUN through NUM_PHASES play phases. A stability budget is
// tracked during play, and the game ends in SUCCESS or FAIL.
// Optional feature: define PHASE_SEQUENCER_PAUSE_EN to enable the RUN <-> PAUSE toggle.
module phase_sequencer #(
   parameter int unsigned NUM_PHASES = 4,
   parameter int unsigned STAB_MAX   = 9,
   parameter int unsigned STAB_W     = 4,
   parameter int unsigned PH_W       = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_btn,
   input  logic              phase_clear,
   input  logic              time_out,
   input  logic              puzzle_fail,
   input  logic              event_fail,
   input  logic              puzzle_correct,
   input  logic              pause_req,
   output logic [2:0]        state,
   output logic [PH_W-1:0]   phase_idx,
   output logic [STAB_W-1:0] stability,
   output logic              game_enable,
   output logic              timer_reset,
   output logic              game_clear,
   output logic              game_over
);

   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StRun     = 3'd1,
      StSuccess = 3'd2,
      StFail    = 3'd3,
      StPause   = 3'd4
   } state_e;

   localparam int unsigned SumW = STAB_W + 2;
   localparam logic [PH_W-1:0]   LastPhase = PH_W'(NUM_PHASES - 1);
   localparam logic [STAB_W-1:0] StabMax   = STAB_W'(STAB_MAX);

   state_e            state_q, state_d;
   logic [PH_W-1:0]   phase_q, phase_d;
   logic [STAB_W-1:0] stab_q, stab_d;
   logic              tr_pulse_q, tr_pulse_d;

   logic start_hist_q, pfail_hist_q, efail_hist_q, pcorr_hist_q, pause_hist_q;
   logic start_edge, pfail_edge, efail_edge, pcorr_edge, pause_edge;

   logic [SumW-1:0]   stab_sum;
   logic [STAB_W-1:0] stab_next;

   assign start_edge = start_btn      & ~start_hist_q;
   assign pfail_edge = puzzle_fail    & ~pfail_hist_q;
   assign efail_edge = event_fail     & ~efail_hist_q;
   assign pcorr_edge = puzzle_correct & ~pcorr_hist_q;
   assign pause_edge = pause_req      & ~pause_hist_q;

`ifndef PHASE_SEQUENCER_PAUSE_EN
   // pause_req is accepted but has no effect in this build.
   logic unused_pause_edge;
   assign unused_pause_edge = pause_edge;
`endif

   // Stability arithmetic is widened by two bits so underflow shows up in the MSB.
   always_comb begin
      stab_sum  = {2'b00, stab_q}
                + {{(SumW-1){1'b0}}, pcorr_edge}
                - {{(SumW-1){1'b0}}, pfail_edge}
                - {{(SumW-1){1'b0}}, efail_edge};
      stab_next = stab_sum[STAB_W-1:0];
      if (stab_sum[SumW-1]) begin
         stab_next = '0;
      end else if (stab_sum > SumW'(STAB_MAX)) begin
         stab_next = StabMax;
      end
   end

   // Next-state, phase, stability and timer pulse decisions.
   always_comb begin
      state_d    = state_q;
      phase_d    = phase_q;
      stab_d     = stab_q;
      tr_pulse_d = 1'b0;
      case (state_q)
         StIdle: begin
            phase_d = '0;
            stab_d  = StabMax;
            if (start_edge) begin
               state_d    = StRun;
               tr_pulse_d = 1'b1;
            end
         end
         StRun: begin
            stab_d = stab_next;
            if (time_out) begin
               state_d = StFail;
            end else if (stab_q == '0) begin
               state_d = StFail;
`ifdef PHASE_SEQUENCER_PAUSE_EN
            end else if (pause_edge) begin
               state_d = StPause;
`endif
            end else if (phase_clear) begin
               if (phase_q == LastPhase) begin
                  state_d = StSuccess;
               end else begin
                  phase_d    = phase_q + 1'b1;
                  tr_pulse_d = 1'b1;
               end
            end
         end
         StSuccess, StFail: begin
            if (start_edge) begin
               state_d = StIdle;
               phase_d = '0;
               stab_d  = StabMax;
            end
         end
`ifdef PHASE_SEQUENCER_PAUSE_EN
         StPause: begin
            if (pause_edge) begin
               state_d = StRun;
            end
         end
`endif
         default: begin
            state_d = StIdle;
            phase_d = '0;
            stab_d  = StabMax;
         end
      endcase
   end

   // State, counters, timer pulse and edge-history registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         phase_q      <= '0;
         stab_q       <= StabMax;
         tr_pulse_q   <= 1'b0;
         start_hist_q <= 1'b0;
         pfail_hist_q <= 1'b0;
         efail_hist_q <= 1'b0;
         pcorr_hist_q <= 1'b0;
         pause_hist_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         phase_q      <= phase_d;
         stab_q       <= stab_d;
         tr_pulse_q   <= tr_pulse_d;
         start_hist_q <= start_btn;
         pfail_hist_q <= puzzle_fail;
         efail_hist_q <= event_fail;
         pcorr_hist_q <= puzzle_correct;
         pause_hist_q <= pause_req;
      end
   end

   assign state       = state_q;
   assign phase_idx   = phase_q;
   assign stability   = stab_q;
   assign game_enable = (state_q == StRun);
   assign game_clear  = (state_q == StSuccess);
   assign game_over   = (state_q == StFail);
   assign timer_reset = (state_q == StIdle) | tr_pulse_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer: the default-parameter instance (a) and
// a single-phase instance (b). They share stimulus and have separate resets.
module tb_phase_sequencer;

   logic clk = 1'b0;
   logic rst_a, rst_b;
   logic start_btn, phase_clear, time_out, puzzle_fail, event_fail, puzzle_correct, pause_req;

   logic [2:0] a_state, b_state;
   logic [3:0] a_phase, a_stab;
   logic [0:0] b_phase;
   logic [1:0] b_stab;
   logic a_en, a_tr, a_clr, a_ovr;
   logic b_en, b_tr, b_clr, b_ovr;

   int n_checks = 0;
   int n_errors = 0;
   int tr_count = 0;
   bit tr_mon   = 1'b0;

   always #5 clk = ~clk;

   phase_sequencer u_dut_a (
      .clk(clk), .rst_n(rst_a), .start_btn(start_btn), .phase_clear(phase_clear),
      .time_out(time_out), .puzzle_fail(puzzle_fail), .event_fail(event_fail),
      .puzzle_correct(puzzle_correct), .pause_req(pause_req), .state(a_state),
      .phase_idx(a_phase), .stability(a_stab), .game_enable(a_en), .timer_reset(a_tr),
      .game_clear(a_clr), .game_over(a_ovr)
   );

   phase_sequencer #(.NUM_PHASES(1), .STAB_MAX(3), .STAB_W(2), .PH_W(1)) u_dut_b (
      .clk(clk), .rst_n(rst_b), .start_btn(start_btn), .phase_clear(phase_clear),
      .time_out(time_out), .puzzle_fail(puzzle_fail), .event_fail(event_fail),
      .puzzle_correct(puzzle_correct), .pause_req(pause_req), .state(b_state),
      .phase_idx(b_phase), .stability(b_stab), .game_enable(b_en), .timer_reset(b_tr),
      .game_clear(b_clr), .game_over(b_ovr)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic check_a(input string tag, input int st, input int ph, input int sb);
      check({tag, ".state"}, 32'(a_state), st);
      check({tag, ".phase"}, 32'(a_phase), ph);
      check({tag, ".stab"},  32'(a_stab),  sb);
   endtask

   // Outputs are sampled 1 time unit after the active edge.
   task automatic step();
      @(posedge clk);
      #1;
      if (tr_mon && a_state != 3'd0 && a_tr) tr_count++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic pulse_start();
      start_btn = 1'b1; step(); start_btn = 1'b0; step();
   endtask

   task automatic pulse_clear();
      phase_clear = 1'b1; step(); phase_clear = 1'b0; step();
   endtask

   task automatic pulse_pfail();
      puzzle_fail = 1'b1; step(); puzzle_fail = 1'b0; step();
   endtask

   task automatic pulse_pause();
      pause_req = 1'b1; step(); pause_req = 1'b0; step();
   endtask

   initial begin
      rst_a = 1'b0; rst_b = 1'b0;
      start_btn = 0; phase_clear = 0; time_out = 0; puzzle_fail = 0;
      event_fail = 0; puzzle_correct = 0; pause_req = 0;
      idle(3);

      // Reset values
      check_a("reset", 0, 0, 9);
      check("reset.timer_reset", 32'(a_tr), 1);
      check("reset.game_enable", 32'(a_en), 0);
      check("reset.game_over",   32'(a_ovr), 0);
      rst_a = 1'b1;
      idle(2);

      // Full play through four phases
      tr_mon = 1'b1;
      start_btn = 1'b1; step(); start_btn = 1'b0;
      check_a("start", 1, 0, 9);
      check("start.game_enable", 32'(a_en), 1);
      check("start.timer_pulse", 32'(a_tr), 1);
      step();
      check("start.timer_low", 32'(a_tr), 0);
      for (int k = 0; k < 4; k++) begin
         idle(5);
         phase_clear = 1'b1; step(); phase_clear = 1'b0;
         if (k < 3) begin
            check_a("advance", 1, k + 1, 9);
            check("advance.timer_pulse", 32'(a_tr), 1);
         end else begin
            check_a("success", 2, 3, 9);
            check("success.game_clear", 32'(a_clr), 1);
         end
         step();
      end
      idle(3);
      tr_mon = 1'b0;
      check("timer_pulse_count", 32'(tr_count), 4);

      // Start edge from SUCCESS only returns to IDLE
      pulse_start();
      check_a("success_to_idle", 0, 0, 9);
      pulse_start();
      check_a("restart_run", 1, 0, 9);

      // Nine fail edges drain stability, then FAIL
      for (int i = 1; i <= 9; i++) begin
         puzzle_fail = 1'b1; step(); puzzle_fail = 1'b0;
         check("drain.stab", 32'(a_stab), 9 - i);
         step();
         check("drain.state", 32'(a_state), (i < 9) ? 1 : 3);
      end
      check("drain.game_over", 32'(a_ovr), 1);
      pulse_pfail();
      check_a("fail_frozen", 3, 0, 0);

      // Clamp at ceiling, then simultaneous fail edges at stability 1
      pulse_start();
      pulse_start();
      check_a("restart2", 1, 0, 9);
      puzzle_correct = 1'b1; step(); puzzle_correct = 1'b0; step();
      check("clamp_top", 32'(a_stab), 9);
      for (int i = 0; i < 8; i++) pulse_pfail();
      check("stab_one", 32'(a_stab), 1);
      puzzle_fail = 1'b1; event_fail = 1'b1; puzzle_correct = 1'b1; step();
      puzzle_fail = 1'b0; event_fail = 1'b0; puzzle_correct = 1'b0;
      check_a("dual_fail", 1, 0, 0);
      step();
      check("dual_fail.state", 32'(a_state), 3);

      // time_out beats phase_clear on the last phase
      pulse_start();
      pulse_start();
      for (int i = 0; i < 3; i++) pulse_clear();
      check("at_last_phase", 32'(a_phase), 3);
      phase_clear = 1'b1; time_out = 1'b1; step();
      phase_clear = 1'b0; time_out = 1'b0;
      check_a("timeout_wins", 3, 3, 9);
      check("timeout_wins.game_clear", 32'(a_clr), 0);

      pulse_start();
      pulse_start();
      pulse_clear();
      pulse_clear();
      for (int i = 0; i < 4; i++) pulse_pfail();
      check_a("pre_pause", 1, 2, 5);
`ifdef PHASE_SEQUENCER_PAUSE_EN
      pulse_pause();
      check_a("paused", 4, 2, 5);
      puzzle_fail = 1'b1; time_out = 1'b1; phase_clear = 1'b1; step();
      puzzle_fail = 1'b0; time_out = 1'b0; phase_clear = 1'b0; step();
      check_a("paused_hold", 4, 2, 5);
      check("paused.timer_reset", 32'(a_tr), 0);
      pulse_start();
      check("paused_start_ignored", 32'(a_state), 4);
      pulse_pause();
      check_a("resumed", 1, 2, 5);
`else
      pulse_pause();
      check_a("pause_ignored", 1, 2, 5);
`endif

      // Single-phase instance
      rst_b = 1'b1;
      idle(2);
      pulse_start();
      check("b.run", 32'(b_state), 1);
      check("b.stab", 32'(b_stab), 3);
      pulse_clear();
      check("b.success", 32'(b_state), 2);
      pulse_start();
      check("b.idle", 32'(b_state), 0);
      check("b.idle_stab", 32'(b_stab), 3);
      pulse_start();
      pulse_pfail();
      check("b.run_stab", 32'(b_stab), 2);
      #2;
      rst_b = 1'b0;
      #1;
      check("b.async_reset_state", 32'(b_state), 0);
      check("b.async_reset_stab", 32'(b_stab), 3);
      check("b.async_reset_phase", 32'(b_phase), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
